data_mem_responder: RTL and testbench

Memory-side responder for the data-memory port of the MIPS32 core. It accepts the single-bit read command and 4-bit byte-lane write command issued by the pipeline's data memory controller and services them from an internal word-organised RAM. It inserts a programmable number of wait states, then pulses `DataMem_Ready` for one cycle, with `ReadData` valid in that cycle. It sits between the MEM-stage controller and the data RAM, and serves both as the simulation data memory and as the synthesizable on-chip data store.

---
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS32 MEM stage: word-organised RAM with byte-lane
// writes, a programmable number of wait states, and a registered one-cycle Ready pulse.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [3:0]  WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] ReadData,
    output logic        DataMem_Ready,
    output logic        Busy
);

    if (READ_WAIT > 15 || WRITE_WAIT > 15) begin : g_wait_range_check
        $error("data_mem_responder: READ_WAIT/WRITE_WAIT must be in 0..15");
    end

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0]  RD_WAIT_C = 4'(READ_WAIT);
    localparam logic [3:0]  WR_WAIT_C = 4'(WRITE_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              we_q, we_d;
    logic                    re_q, re_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic [31:0]             mem_q [DEPTH];

    logic                    req;
    logic [3:0]              load_cnt;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [31:0]             c_wdata;
    logic [3:0]              c_we;
    logic                    c_re;

    // Byte offset and bits above the RAM index simply alias.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

    assign req      = ReadEnable | (|WriteEnable);
    assign load_cnt = (|WriteEnable) ? WR_WAIT_C : RD_WAIT_C;

    // A zero-wait request commits on its accept edge, so the commit path
    // must take the live inputs rather than the holding registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        commit  = 1'b0;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_we    = we_q;
        c_re    = re_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = Address[ADDR_WIDTH+1:2];
                    wdata_d = WriteData;
                    we_d    = WriteEnable;
                    re_d    = ReadEnable;
                    cnt_d   = load_cnt;
                    if (load_cnt != 4'd0) begin
                        state_d = ST_WAIT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_ACK;
                        ready_d = 1'b1;
                        commit  = 1'b1;
                        c_addr  = Address[ADDR_WIDTH+1:2];
                        c_wdata = WriteData;
                        c_we    = WriteEnable;
                        c_re    = ReadEnable;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACK;
                    ready_d = 1'b1;
                    commit  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rdata_d = (commit && c_re) ? mem_q[c_addr] : rdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            re_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // No reset on the array; reset forces IDLE, which suppresses any pending commit.
    always_ff @(posedge clock) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (c_we[i]) begin
                    mem_q[c_addr][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ReadData      = rdata_q;
    assign DataMem_Ready = ready_q;
    assign Busy          = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: default wait counts plus a
// zero-wait instance.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [3:0]  WriteEnable;
    logic        ReadEnable;
    logic [31:0] ReadData;
    logic        DataMem_Ready;
    logic        Busy;

    logic [31:0] z_addr;
    logic [31:0] z_wdata;
    logic [3:0]  z_we;
    logic        z_re;
    logic [31:0] z_rdata;
    logic        z_ready;
    logic        z_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .READ_WAIT  (2),
        .WRITE_WAIT (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .Address       (Address),
        .WriteData     (WriteData),
        .WriteEnable   (WriteEnable),
        .ReadEnable    (ReadEnable),
        .ReadData      (ReadData),
        .DataMem_Ready (DataMem_Ready),
        .Busy          (Busy)
    );

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .READ_WAIT  (0),
        .WRITE_WAIT (0)
    ) dut0 (
        .clock         (clock),
        .reset         (reset),
        .Address       (z_addr),
        .WriteData     (z_wdata),
        .WriteEnable   (z_we),
        .ReadEnable    (z_re),
        .ReadData      (z_rdata),
        .DataMem_Ready (z_ready),
        .Busy          (z_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle after ACK.
    task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic re, output int lat, output logic [31:0] rd);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        rd  = '0;
        Address     = a;
        WriteData   = wd;
        WriteEnable = we;
        ReadEnable  = re;
        while (!ok && lat < 20) begin
            @(negedge clock);
            lat++;
            if (DataMem_Ready) begin
                ok = 1'b1;
                rd = ReadData;
            end
        end
        check_eq("xact_done", 32'(ok), 32'd1);
        ReadEnable  = 1'b0;
        WriteEnable = '0;
        @(negedge clock);
        check_eq("ready_one_cycle", 32'(DataMem_Ready), 32'd0);
    endtask

    initial begin
        int          lat, lat1;
        logic [31:0] rd;

        reset = 1'b1;
        Address = '0; WriteData = '0; WriteEnable = '0; ReadEnable = 1'b0;
        z_addr = '0; z_wdata = '0; z_we = '0; z_re = 1'b0;

        @(negedge clock);
        check_eq("rst_rdata", ReadData, 32'h0);
        check_eq("rst_ready", 32'(DataMem_Ready), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        reset = 1'b0;

        // Preload through the write port
        xact(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd);
        check_eq("wr_latency", 32'(lat), 32'd2);
        xact(32'h4, 32'h11223344, 4'hF, 1'b0, lat, rd);
        xact(32'h8, 32'h00000000, 4'hF, 1'b0, lat, rd);
        xact(32'h0, 32'h00000009, 4'hF, 1'b0, lat, rd);
        check_eq("rdata_untouched_by_writes", ReadData, 32'h0);

        // Word read, cycle by cycle
        Address = 32'h10; ReadEnable = 1'b1;
        @(negedge clock);
        check_eq("rd_c1_busy", 32'(Busy), 32'd1);
        check_eq("rd_c1_ready", 32'(DataMem_Ready), 32'd0);
        @(negedge clock);
        check_eq("rd_c2_busy", 32'(Busy), 32'd1);
        check_eq("rd_c2_ready", 32'(DataMem_Ready), 32'd0);
        @(negedge clock);
        check_eq("rd_c3_ready", 32'(DataMem_Ready), 32'd1);
        check_eq("rd_c3_busy", 32'(Busy), 32'd0);
        check_eq("rd_c3_data", ReadData, 32'hDEADBEEF);
        ReadEnable = 1'b0;
        @(negedge clock);
        check_eq("rd_c4_ready", 32'(DataMem_Ready), 32'd0);
        check_eq("rd_c4_data", ReadData, 32'hDEADBEEF);

        xact(32'h8000_1013, 32'h0, 4'h0, 1'b1, lat, rd);
        check_eq("alias_rd", rd, 32'hDEADBEEF);
        check_eq("rd_latency", 32'(lat), 32'd3);

        // Byte-lane write
        xact(32'h4, 32'hAAAAAAAA, 4'b0100, 1'b0, lat, rd);
        check_eq("lane_wr_keeps_rdata", ReadData, 32'hDEADBEEF);
        xact(32'h4, 32'h0, 4'h0, 1'b1, lat, rd);
        check_eq("lane_rd", rd, 32'h11AA3344);

        // Back-to-back write then read of the same word
        xact(32'hC, 32'h12345678, 4'hF, 1'b0, lat1, rd);
        xact(32'hC, 32'h0, 4'h0, 1'b1, lat, rd);
        check_eq("b2b_rd", rd, 32'h12345678);
        check_eq("b2b_total", 32'(lat1 + 1 + lat), 32'd6);

        // Reset while in WAIT discards the write
        Address = 32'h8; WriteData = 32'hFFFFFFFF; WriteEnable = 4'hF;
        @(negedge clock);
        check_eq("mid_rst_busy_before", 32'(Busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ready", 32'(DataMem_Ready), 32'd0);
        check_eq("mid_rst_busy", 32'(Busy), 32'd0);
        check_eq("mid_rst_rdata", ReadData, 32'h0);
        WriteEnable = '0;
        @(negedge clock);
        reset = 1'b0;
        xact(32'h8, 32'h0, 4'h0, 1'b1, lat, rd);
        check_eq("mid_rst_mem", rd, 32'h0);

        // Reset during ACK: Ready drops, the committed write stands
        Address = 32'h14; WriteData = 32'hCAFEF00D; WriteEnable = 4'hF;
        @(negedge clock);
        @(negedge clock);
        check_eq("ack_rst_ready_before", 32'(DataMem_Ready), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("ack_rst_ready", 32'(DataMem_Ready), 32'd0);
        WriteEnable = '0;
        @(negedge clock);
        reset = 1'b0;
        xact(32'h14, 32'h0, 4'h0, 1'b1, lat, rd);
        check_eq("ack_rst_mem", rd, 32'hCAFEF00D);

        // Simultaneous read and write
        xact(32'h0, 32'h5, 4'hF, 1'b1, lat, rd);
        check_eq("rw_old_data", rd, 32'h9);
        check_eq("rw_latency", 32'(lat), 32'd2);
        xact(32'h0, 32'h0, 4'h0, 1'b1, lat, rd);
        check_eq("rw_new_data", rd, 32'h5);

        // Zero-wait instance
        z_addr = 32'h10; z_wdata = 32'h0BADCAFE; z_we = 4'hF;
        @(negedge clock);
        check_eq("z_wr_ready", 32'(z_ready), 32'd1);
        check_eq("z_wr_busy", 32'(z_busy), 32'd0);
        z_we = '0;
        @(negedge clock);
        check_eq("z_wr_ready_drop", 32'(z_ready), 32'd0);
        z_re = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check_eq("z_rd_ready", 32'(z_ready), 32'(i % 2 == 0));
            check_eq("z_rd_busy", 32'(z_busy), 32'd0);
            check_eq("z_rd_data", z_rdata, 32'h0BADCAFE);
        end
        z_re = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
